cpu_mult_pipe: RTL and testbench

Parametrised, pipelined integer multiplier for the CPU M-stage. It succeeds the fixed 16×16 three-cell multiply block. The block splits DATA_W-bit operands into PART_W-bit slices, registers all slice products, and accumulates them into a full 2·DATA_W product. It applies signed/unsigned correction and returns the low or high word under a valid/ready handshake with stall and flush.

---
 rtl/cpu_mult_pkg.sv | 21 ++
 rtl/cpu_mult_part.sv | 25 ++
 rtl/cpu_mult_pipe.sv | 166 ++++++++++++++++
 tb/tb_cpu_mult_pipe.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mult_pkg.sv
// Shared types and constants for the pipelined M-stage multiplier.
// Optional high-word support is controlled by CPU_MULT_HI_EN.
package cpu_mult_pkg;

  typedef enum logic [1:0] {
    MUL_LO = 2'b00,
    MULXUU = 2'b01,
    MULXSU = 2'b10,
    MULXSS = 2'b11
  } mult_op_t;

  localparam int DEFAULT_PART_W = 16;

  function automatic int num_parts(
    input int data_w,
    input int part_w
  );
    return data_w / part_w;
  endfunction

endpackage

// File: rtl/cpu_mult_part.sv
// One PART_W x PART_W unsigned registered multiplier cell.
// Holds its product when disabled; cleared asynchronously.
module cpu_mult_part
  import cpu_mult_pkg::*;
#(
  parameter int PART_W = DEFAULT_PART_W
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  en,
  input  logic [PART_W-1:0]     a,
  input  logic [PART_W-1:0]     b,
  output logic [2*PART_W-1:0]   p
);

  // Registered unsigned slice product
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      p <= '0;
    end else if (en) begin
      p <= {{PART_W{1'b0}}, a} * {{PART_W{1'b0}}, b};
    end
  end

endmodule

// File: rtl/cpu_mult_pipe.sv
// Three-stage sliced integer multiplier with valid/ready, stall, flush.
// Define CPU_MULT_HI_EN to build high-word ops; otherwise low word only.
module cpu_mult_pipe
  import cpu_mult_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PART_W = DEFAULT_PART_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result
);

  localparam int N = num_parts(DATA_W, PART_W);
`ifdef CPU_MULT_HI_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif
  localparam int SUM_W = HI_EN ? 2 * DATA_W : DATA_W;

  logic                adv;
  logic                v1;
  logic                v2;
  logic [2*PART_W-1:0] p [N][N];
  logic [SUM_W-1:0]    sum_c;
  logic [SUM_W-1:0]    sum2;
  logic [DATA_W-1:0]   res_c;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      if (HI_EN || (gi + gj < N)) begin : g_cell
        cpu_mult_part #(
          .PART_W (PART_W)
        ) u_part (
          .clk (clk),
          .clr (reset),
          .en  (adv),
          .a   (in_src1[gi*PART_W +: PART_W]),
          .b   (in_src2[gj*PART_W +: PART_W]),
          .p   (p[gi][gj])
        );
      end else begin : g_none
        assign p[gi][gj] = '0;
      end
    end
  end

  // Valid pipeline: flush kills all stages, stall holds them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
    end else if (flush) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
    end
  end

  // Shift-and-add of all slice products, wrap discarded
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        sum_c = sum_c +
          (SUM_W'(p[i][j]) << (PART_W * (i + j)));
      end
    end
  end

  // S2 product register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum2 <= '0;
    end else if (adv) begin
      sum2 <= sum_c;
    end
  end

`ifdef CPU_MULT_HI_EN
  mult_op_t          op_in;
  mult_op_t          op1;
  mult_op_t          op2;
  logic              sa;
  logic              sb;
  logic              an1;
  logic              bn1;
  logic              an2;
  logic              bn2;
  logic [DATA_W-1:0] a1;
  logic [DATA_W-1:0] b1;
  logic [DATA_W-1:0] a2;
  logic [DATA_W-1:0] b2;
  logic [DATA_W-1:0] hi;

  assign op_in = mult_op_t'(in_op);
  assign sa    = (op_in == MULXSU) || (op_in == MULXSS);
  assign sb    = (op_in == MULXSS);

  // Op, sign flags and operand copies travel alongside the products
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op1 <= MUL_LO;
      op2 <= MUL_LO;
      an1 <= 1'b0;
      bn1 <= 1'b0;
      an2 <= 1'b0;
      bn2 <= 1'b0;
      a1  <= '0;
      b1  <= '0;
      a2  <= '0;
      b2  <= '0;
    end else if (adv) begin
      op1 <= op_in;
      an1 <= in_src1[DATA_W-1] & sa;
      bn1 <= in_src2[DATA_W-1] & sb;
      a1  <= in_src1;
      b1  <= in_src2;
      op2 <= op1;
      an2 <= an1;
      bn2 <= bn1;
      a2  <= a1;
      b2  <= b1;
    end
  end

  // Signed correction of the high word and word select
  always_comb begin
    hi = sum2[2*DATA_W-1:DATA_W]
       - (an2 ? b2 : '0)
       - (bn2 ? a2 : '0);
    res_c = (op2 == MUL_LO) ? sum2[DATA_W-1:0] : hi;
  end
`else
  logic unused_op;
  assign unused_op = ^in_op;
  assign res_c     = sum2;
`endif

  // S3 result register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_result <= '0;
    end else if (adv) begin
      out_result <= res_c;
    end
  end

endmodule

// File: tb/tb_cpu_mult_pipe.sv
// Directed self-checking bench for cpu_mult_pipe (32- and 64-bit builds).
// Expected high-word results depend on CPU_MULT_HI_EN.
module tb_cpu_mult_pipe;

`ifdef CPU_MULT_HI_EN
  localparam bit HI = 1'b1;
`else
  localparam bit HI = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [31:0] in_src1 = '0;
  logic [31:0] in_src2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;

  logic        in_valid64 = 1'b0;
  logic        in_ready64;
  logic [1:0]  in_op64 = 2'b00;
  logic [63:0] in_a64 = '0;
  logic [63:0] in_b64 = '0;
  logic        out_valid64;
  logic        out_ready64 = 1'b1;
  logic [63:0] out_result64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_mult_pipe #(.DATA_W(32), .PART_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  cpu_mult_pipe #(.DATA_W(64), .PART_W(16)) dut64 (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid64),
    .in_ready   (in_ready64),
    .in_op      (in_op64),
    .in_src1    (in_a64),
    .in_src2    (in_b64),
    .out_valid  (out_valid64),
    .out_ready  (out_ready64),
    .out_result (out_result64)
  );

  task automatic op32(
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] r,
    output int          lat
  );
    in_valid = 1'b1;
    in_op    = op;
    in_src1  = a;
    in_src2  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    r = out_result;
    @(posedge clk); #1;
  endtask

  task automatic op64(
    input  logic [1:0]  op,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] r,
    output int          lat
  );
    in_valid64 = 1'b1;
    in_op64    = op;
    in_a64     = a;
    in_b64     = b;
    @(posedge clk); #1;
    in_valid64 = 1'b0;
    lat = 1;
    while (!out_valid64 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    r = out_result64;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    #2;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %0b want 0", out_valid);
    end
    checks++;
    if (out_result !== 32'h0) begin
      errors++;
      $display("FAIL reset_result got %h want 0", out_result);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %0b want 1", in_ready);
    end
    checks++;
    if (out_valid64 !== 1'b0 || out_result64 !== 64'h0) begin
      errors++;
      $display("FAIL reset_64 got %0b/%h want 0/0",
               out_valid64, out_result64);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [1:0]  ops [5] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b11};
    logic [31:0] va  [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'h80000000};
    logic [31:0] vb  [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'hFFFFFFFF, 32'h00000002,
                             32'h80000000};
    logic [31:0] eh  [5] = '{32'h00000001, 32'hFFFFFFFE,
                             32'h00000000, 32'hFFFFFFFF,
                             32'h40000000};
    logic [31:0] el  [5] = '{32'h00000001, 32'h00000001,
                             32'h00000001, 32'hFFFFFFFE,
                             32'h00000000};
    logic [31:0] r;
    logic [31:0] exp;
    int          lat;
    for (int k = 0; k < 5; k++) begin
      op32(ops[k], va[k], vb[k], r, lat);
      exp = HI ? eh[k] : el[k];
      checks++;
      if (r !== exp) begin
        errors++;
        $display("FAIL basic_%0d result got %h want %h", k, r, exp);
      end
      checks++;
      if (lat !== 3) begin
        errors++;
        $display("FAIL basic_%0d latency got %0d want 3", k, lat);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0]  bo [4] = '{2'b00, 2'b00, 2'b00, 2'b01};
    logic [31:0] ba [4] = '{32'd7, 32'h12345678,
                            32'h0000FFFF, 32'h80000000};
    logic [31:0] bb [4] = '{32'd6, 32'h00000010,
                            32'h0000FFFF, 32'h00000004};
    logic [31:0] ex [4];
    logic [31:0] res [4];
    logic [31:0] held = '0;
    int cyc = 0;
    int idx = 0;
    int got = 0;
    int extra = 0;
    ex[0] = 32'h0000002A;
    ex[1] = 32'h23456780;
    ex[2] = 32'hFFFE0001;
    ex[3] = HI ? 32'h00000002 : 32'h00000000;
    while (got < 4 && cyc < 40) begin
      out_ready = !(cyc == 3 || cyc == 4);
      in_valid  = (idx < 4);
      if (idx < 4) begin
        in_op   = bo[idx];
        in_src1 = ba[idx];
        in_src2 = bb[idx];
      end
      #1;
      if (cyc == 3 || cyc == 4) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL b2b_stall_%0d rdy/vld got %0b/%0b want 0/1",
                   cyc, in_ready, out_valid);
        end
      end
      if (cyc == 3) held = out_result;
      if (cyc == 4) begin
        checks++;
        if (out_result !== held) begin
          errors++;
          $display("FAIL b2b_hold got %h want %h", out_result, held);
        end
      end
      if (out_valid && out_ready) begin
        res[got] = out_result;
        got++;
      end
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got !== 4) begin
      errors++;
      $display("FAIL b2b_count got %0d want 4", got);
    end
    for (int k = 0; k < got; k++) begin
      checks++;
      if (res[k] !== ex[k]) begin
        errors++;
        $display("FAIL b2b_res_%0d got %h want %h", k, res[k], ex[k]);
      end
    end
    repeat (4) begin
      if (out_valid) extra++;
      @(posedge clk); #1;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL b2b_dup got %0d extra want 0", extra);
    end
  endtask

  task automatic test_flush;
    logic [31:0] r;
    int lat;
    int seen = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 2'b00;
    in_src1 = 32'd3; in_src2 = 32'd5;
    @(posedge clk); #1;
    in_src1 = 32'd9; in_src2 = 32'd9;
    @(posedge clk); #1;
    in_src1 = 32'd2; in_src2 = 32'd2;
    flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_ready got %0b want 1", in_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    repeat (5) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL flush_drop got %0d results want 0", seen);
    end
    op32(2'b00, 32'd1000, 32'd1000, r, lat);
    checks++;
    if (r !== 32'd1000000) begin
      errors++;
      $display("FAIL flush_next got %h want %h", r, 32'd1000000);
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL flush_next_lat got %0d want 3", lat);
    end
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 2'b00;
    in_src1 = 32'd4; in_src2 = 32'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'd16) begin
      errors++;
      $display("FAIL flush_stall_pre got %0b/%h want 1/%h",
               out_valid, out_result, 32'd16);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall got %0b want 0", out_valid);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid;
    logic [31:0] r;
    int lat;
    int seen = 0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 2'b00;
    in_src1 = 32'd11; in_src2 = 32'd13;
    @(posedge clk); #1;
    in_src1 = 32'd17; in_src2 = 32'd19;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 2;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'd143) begin
      errors++;
      $display("FAIL rmid_pre got %0b/%h want 1/%h",
               out_valid, out_result, 32'd143);
    end
    #3;
    reset = 1'b1;
    flush = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_result !== 32'h0) begin
      errors++;
      $display("FAIL rmid_async got %0b/%h want 0/0",
               out_valid, out_result);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rmid_ready got %0b want 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    repeat (4) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rmid_stale got %0d results want 0", seen);
    end
    op32(2'b00, 32'd21, 32'd2, r, lat);
    checks++;
    if (r !== 32'd42 || lat !== 3) begin
      errors++;
      $display("FAIL rmid_after got %h lat %0d want %h lat 3",
               r, lat, 32'd42);
    end
  endtask

  task automatic test_wide64;
    logic [63:0] r;
    logic [63:0] exp;
    int lat;
    op64(2'b01, 64'h0000000100000000, 64'h0000000100000000, r, lat);
    exp = HI ? 64'h1 : 64'h0;
    checks++;
    if (r !== exp || lat !== 3) begin
      errors++;
      $display("FAIL w64_xuu got %h lat %0d want %h lat 3",
               r, lat, exp);
    end
    op64(2'b00, 64'h0000000100000000, 64'h0000000100000000, r, lat);
    checks++;
    if (r !== 64'h0 || lat !== 3) begin
      errors++;
      $display("FAIL w64_lo got %h lat %0d want 0 lat 3", r, lat);
    end
    op64(2'b00, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, r, lat);
    checks++;
    if (r !== 64'h1) begin
      errors++;
      $display("FAIL w64_lo_ones got %h want 1", r);
    end
    op64(2'b11, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, r, lat);
    exp = HI ? 64'h0 : 64'h1;
    checks++;
    if (r !== exp) begin
      errors++;
      $display("FAIL w64_xss got %h want %h", r, exp);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_flush;
    test_reset_mid;
    test_wide64;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
